// File: rtl/fetch_stage_if.sv
// Signal bundle between the LC-3b fetch stage, instruction memory, decode and the redirect sources.
// The master modport is the fetch stage; the slave modport is everything around it.
interface fetch_stage_if;
   logic [15:0] imem_address;
   logic        imem_read;
   logic [15:0] imem_rdata;
   logic        imem_resp;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        if_id_valid;
   logic [15:0] if_id_instruction;
   logic [15:0] if_id_pc;
   logic [1:0]  dbg_state;
   logic        dbg_skid_valid;

   // imem: one request is outstanding while imem_read=1; exactly one imem_resp answers it.
   // IF/ID: a word is handed to decode at an edge where if_id_valid=1 and stall=0 (and no redirect).
   modport master (
      output imem_address, imem_read, if_id_valid, if_id_instruction, if_id_pc,
             dbg_state, dbg_skid_valid,
      input  imem_rdata, imem_resp, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_address, imem_read, if_id_valid, if_id_instruction, if_id_pc,
             dbg_state, dbg_skid_valid,
      output imem_rdata, imem_resp, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: PC register, imem read FSM, one-entry skid buffer and the
// IF/ID pipeline register. Redirects discard any in-flight fetch and all buffered words.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_stage_if.master bus
);
   localparam logic [15:0] PC_INIT = RESET_PC & 16'hFFFE;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_pc;
   logic        r_if_id_valid;
   logic [15:0] r_if_id_instr;
   logic [15:0] r_if_id_pc;
   logic        r_skid_valid;
   logic [15:0] r_skid_instr;
   logic [15:0] r_skid_pc;

   logic [15:0] w_pc_plus2;
   logic [15:0] w_redirect_target;
   logic        w_slot_accepts;
   logic        w_take_resp;
   logic        w_load_from_skid;

   assign w_pc_plus2        = r_pc + 16'd2;
   assign w_redirect_target = bus.redirect_pc & 16'hFFFE;
   assign w_slot_accepts    = !r_if_id_valid || !bus.stall;
   // A response coinciding with a redirect belongs to the old path and is never used.
   assign w_take_resp       = (r_state == S_WAIT) && bus.imem_resp && !bus.redirect;
   assign w_load_from_skid  = (r_state == S_IDLE) && r_skid_valid && w_slot_accepts &&
                              !bus.redirect;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.redirect || !r_skid_valid || w_slot_accepts) w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (bus.redirect)                              w_next_state = bus.imem_resp ? S_WAIT : S_DISCARD;
            else if (bus.imem_resp && !w_slot_accepts)     w_next_state = S_IDLE;
         end
         S_DISCARD: begin
            // The pending response retires the stale request even if another redirect lands with it.
            if (bus.imem_resp) w_next_state = S_WAIT;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      bus.imem_read  = (r_state == S_WAIT) || (r_state == S_DISCARD);
      bus.dbg_state  = r_state;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                               r_pc <= PC_INIT;
      else if (bus.redirect)                      r_pc <= w_redirect_target;
      else if (bus.imem_resp && r_state == S_WAIT) r_pc <= w_pc_plus2;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_if_id_valid <= 1'b0;
         r_if_id_instr <= 16'h0000;
         r_if_id_pc    <= 16'h0000;
      end else if (bus.redirect) begin
         r_if_id_valid <= 1'b0;
      end else if (w_take_resp && w_slot_accepts) begin
         r_if_id_valid <= 1'b1;
         r_if_id_instr <= bus.imem_rdata;
         r_if_id_pc    <= w_pc_plus2;
      end else if (w_load_from_skid) begin
         r_if_id_valid <= 1'b1;
         r_if_id_instr <= r_skid_instr;
         r_if_id_pc    <= r_skid_pc;
      end else if (w_slot_accepts) begin
         // Bubble: only valid drops, the payload stays as it was.
         r_if_id_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_skid_valid <= 1'b0;
         r_skid_instr <= 16'h0000;
         r_skid_pc    <= 16'h0000;
      end else if (bus.redirect) begin
         r_skid_valid <= 1'b0;
      end else if (w_take_resp && !w_slot_accepts) begin
         r_skid_valid <= 1'b1;
         r_skid_instr <= bus.imem_rdata;
         r_skid_pc    <= w_pc_plus2;
      end else if (w_load_from_skid) begin
         r_skid_valid <= 1'b0;
      end
   end

   assign bus.imem_address      = r_pc;
   assign bus.if_id_valid       = r_if_id_valid;
   assign bus.if_id_instruction = r_if_id_instr;
   assign bus.if_id_pc          = r_if_id_pc;
   assign bus.dbg_skid_valid    = r_skid_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then random stall/redirect/memory-latency traffic
// checked against an in-order instruction-stream model (word = mem[pc], pc advances by 2).
module tb_fetch_stage;
   logic clk = 1'b0;
   logic reset_n;

   fetch_stage_if bus ();
   fetch_stage_if bus_w ();

   fetch_stage #(.RESET_PC(16'h3000)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   fetch_stage #(.RESET_PC(16'hFFFE)) u_dut_wrap (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_w)
   );

   always #5 clk = ~clk;

   int          n_checks   = 0;
   int          n_pass     = 0;
   int          n_consumed = 0;
   int          lat        = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exp_pc;
   logic        prev_outstanding;
   logic        prev_rd;
   logic [15:0] prev_addr;
   logic [15:0] prev_target;

   // Instruction memory contents: three fixed words, a unique word for every other even address.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h3000: return 16'h1261;
         16'h3002: return 16'h5020;
         16'h3004: return 16'h0E02;
         default:  return {a[7:0], a[15:8]} ^ 16'h1F2E;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_pc           = 16'h3000;
      lat              = 0;
      prev_outstanding = 1'b0;
      prev_rd          = 1'b0;
      prev_addr        = 16'h0000;
      prev_target      = 16'h0000;
   endtask

   // One clock: drive inputs at the falling edge, score the word decode takes at the next
   // rising edge, then sample again at the following falling edge.
   task automatic tick(input logic st, input logic rd, input logic [15:0] rpc,
                       input logic resp, input logic [15:0] rdata);
      logic [47:0] held;
      logic        hold_chk;
      logic [31:0] want;
      if (prev_rd)               chk("redirect_addr", bus.imem_address, prev_target);
      else if (prev_outstanding) chk("addr_stable", bus.imem_address, prev_addr);
      bus.stall       = st;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      bus.imem_resp   = resp;
      bus.imem_rdata  = rdata;
      bus_w.stall       = 1'b0;
      bus_w.redirect    = 1'b0;
      bus_w.redirect_pc = 16'h0000;
      bus_w.imem_resp   = bus_w.imem_read;
      bus_w.imem_rdata  = ~bus_w.imem_address;
      if (bus.if_id_valid && !st && !rd) begin
         if (exp_q.size() == 0) begin
            exp_q.push_back({mem_word(exp_pc), exp_pc + 16'd2});
            exp_pc = exp_pc + 16'd2;
         end
         want = exp_q.pop_front();
         chk("consume", {bus.if_id_instruction, bus.if_id_pc}, want);
         n_consumed++;
      end
      if (rd) begin
         exp_q.delete();
         exp_pc = rpc & 16'hFFFE;
      end
      hold_chk         = bus.if_id_valid && st && !rd;
      held             = {15'd0, bus.if_id_valid, bus.if_id_instruction, bus.if_id_pc};
      prev_rd          = rd;
      prev_target      = rpc & 16'hFFFE;
      prev_outstanding = bus.imem_read && !resp;
      prev_addr        = bus.imem_address;
      @(posedge clk);
      @(negedge clk);
      if (hold_chk)
         chk("stall_hold", {15'd0, bus.if_id_valid, bus.if_id_instruction, bus.if_id_pc}, held);
      else if (!bus.if_id_valid)
         chk("bubble_keep", {bus.if_id_instruction, bus.if_id_pc}, held[31:0]);
   endtask

   task automatic rand_tick();
      logic        st;
      logic        rd;
      logic        resp;
      logic [15:0] rpc;
      st   = ($urandom_range(0, 2) == 0);
      rd   = ($urandom_range(0, 19) == 0);
      rpc  = 16'($urandom);
      resp = 1'b0;
      if (bus.imem_read) begin
         if (lat == 0) begin
            resp = 1'b1;
            lat  = $urandom_range(0, 2);
         end else begin
            lat--;
         end
      end
      tick(st, rd, rpc, resp, mem_word(bus.imem_address));
   endtask

   initial begin
      reset_n = 1'b0;
      bus.stall = 1'b0;   bus.redirect = 1'b0;   bus.redirect_pc = 16'h0;
      bus.imem_resp = 1'b0; bus.imem_rdata = 16'h0;
      bus_w.stall = 1'b0; bus_w.redirect = 1'b0; bus_w.redirect_pc = 16'h0;
      bus_w.imem_resp = 1'b0; bus_w.imem_rdata = 16'h0;
      clear_model();
      @(negedge clk);
      @(negedge clk);

      chk("rst_addr", bus.imem_address, 16'h3000);
      chk("rst_read", bus.imem_read, 1'b0);
      chk("rst_valid", bus.if_id_valid, 1'b0);
      chk("rst_instr", bus.if_id_instruction, 16'h0000);
      chk("rst_pc", bus.if_id_pc, 16'h0000);
      chk("rst_state", bus.dbg_state, 2'd0);
      chk("rst_skid", bus.dbg_skid_valid, 1'b0);
      chk("rst_wrap_addr", bus_w.imem_address, 16'hFFFE);

      reset_n = 1'b1;
      tick(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("first_read", bus.imem_read, 1'b1);
      chk("first_addr", bus.imem_address, 16'h3000);
      chk("first_state", bus.dbg_state, 2'd1);
      chk("first_valid", bus.if_id_valid, 1'b0);
      tick(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("wait_read", bus.imem_read, 1'b1);
      chk("wrap_pc", bus_w.if_id_pc, 16'h0000);
      chk("wrap_valid", bus_w.if_id_valid, 1'b1);
      chk("wrap_instr", bus_w.if_id_instruction, 16'h0001);
      chk("wrap_addr", bus_w.imem_address, 16'h0000);

      // Back-to-back responses.
      tick(1'b0, 1'b0, 16'h0, 1'b1, mem_word(bus.imem_address));
      chk("b2b0", {bus.if_id_valid, bus.if_id_instruction, bus.if_id_pc}, {1'b1, 16'h1261, 16'h3002});
      chk("b2b0_addr", bus.imem_address, 16'h3002);
      tick(1'b0, 1'b0, 16'h0, 1'b1, mem_word(bus.imem_address));
      chk("b2b1", {bus.if_id_valid, bus.if_id_instruction, bus.if_id_pc}, {1'b1, 16'h5020, 16'h3004});
      tick(1'b0, 1'b0, 16'h0, 1'b1, mem_word(bus.imem_address));
      chk("b2b2", {bus.if_id_valid, bus.if_id_instruction, bus.if_id_pc}, {1'b1, 16'h0E02, 16'h3006});

      // Stall while the next word returns: it parks in the skid buffer.
      tick(1'b1, 1'b0, 16'h0, 1'b1, mem_word(bus.imem_address));
      chk("stall_ifid", {bus.if_id_valid, bus.if_id_instruction, bus.if_id_pc}, {1'b1, 16'h0E02, 16'h3006});
      chk("stall_read", bus.imem_read, 1'b0);
      chk("stall_skid", bus.dbg_skid_valid, 1'b1);
      chk("stall_state", bus.dbg_state, 2'd0);
      chk("stall_addr", bus.imem_address, 16'h3008);
      tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("stall2_read", bus.imem_read, 1'b0);
      tick(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("unstall_ifid", {bus.if_id_valid, bus.if_id_instruction, bus.if_id_pc},
          {1'b1, mem_word(16'h3006), 16'h3008});
      chk("unstall_read", bus.imem_read, 1'b1);
      chk("unstall_addr", bus.imem_address, 16'h3008);
      chk("unstall_skid", bus.dbg_skid_valid, 1'b0);

      // Redirect with a request outstanding and no response.
      tick(1'b0, 1'b1, 16'h4001, 1'b0, 16'h0);
      chk("disc_state", bus.dbg_state, 2'd2);
      chk("disc_valid", bus.if_id_valid, 1'b0);
      chk("disc_addr", bus.imem_address, 16'h4000);
      chk("disc_read", bus.imem_read, 1'b1);
      tick(1'b0, 1'b0, 16'h0, 1'b1, mem_word(16'h3008));
      chk("late_valid", bus.if_id_valid, 1'b0);
      chk("late_state", bus.dbg_state, 2'd1);
      chk("late_addr", bus.imem_address, 16'h4000);
      tick(1'b0, 1'b0, 16'h0, 1'b1, mem_word(bus.imem_address));
      chk("target_ifid", {bus.if_id_valid, bus.if_id_instruction, bus.if_id_pc},
          {1'b1, mem_word(16'h4000), 16'h4002});

      // Redirect under stall with the skid buffer full.
      tick(1'b1, 1'b0, 16'h0, 1'b1, mem_word(bus.imem_address));
      chk("skid_full", bus.dbg_skid_valid, 1'b1);
      tick(1'b1, 1'b1, 16'h5000, 1'b0, 16'h0);
      chk("rskid_valid", bus.if_id_valid, 1'b0);
      chk("rskid_skid", bus.dbg_skid_valid, 1'b0);
      chk("rskid_state", bus.dbg_state, 2'd1);
      chk("rskid_addr", bus.imem_address, 16'h5000);
      tick(1'b0, 1'b0, 16'h0, 1'b1, mem_word(bus.imem_address));
      chk("r5_ifid", {bus.if_id_valid, bus.if_id_pc}, {1'b1, 16'h5002});

      // Redirect, response and stall in one cycle.
      tick(1'b1, 1'b1, 16'h6001, 1'b1, 16'hBEEF);
      chk("rrs_valid", bus.if_id_valid, 1'b0);
      chk("rrs_skid", bus.dbg_skid_valid, 1'b0);
      chk("rrs_state", bus.dbg_state, 2'd1);
      chk("rrs_addr", bus.imem_address, 16'h6000);
      chk("rrs_keep", {bus.if_id_instruction, bus.if_id_pc}, {mem_word(16'h5000), 16'h5002});
      tick(1'b0, 1'b0, 16'h0, 1'b1, mem_word(bus.imem_address));
      chk("r6_ifid", {bus.if_id_valid, bus.if_id_instruction, bus.if_id_pc},
          {1'b1, mem_word(16'h6000), 16'h6002});

      // Asynchronous reset in the middle of a WAIT cycle.
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_read", bus.imem_read, 1'b0);
      chk("arst_valid", bus.if_id_valid, 1'b0);
      chk("arst_addr", bus.imem_address, 16'h3000);
      chk("arst_state", bus.dbg_state, 2'd0);
      chk("arst_wrap_read", bus_w.imem_read, 1'b0);
      bus.imem_resp = 1'b0;
      bus.stall     = 1'b0;
      bus.redirect  = 1'b0;
      clear_model();
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 3000; i++) rand_tick();
      chk("progress", n_consumed > 200, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
